// File: rtl/pulse_mon_pkg.sv
// Shared types and defaults for the pulse_seq_monitor slice: FSM state
// encoding, error-bit positions and the phase-successor helper.
package pulse_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_G1   = 3'd2,
        ST_P2   = 3'd3,
        ST_G2   = 3'd4,
        ST_P3   = 3'd5
    } state_t;

    localparam int ERR_SHAPE = 0;
    localparam int ERR_GAP   = 1;
    localparam int ERR_ABORT = 2;

    localparam int DEF_TOL       = 4;
    localparam int DEF_TIMEOUT   = 200000;
    localparam int DEF_MIN_WIDTH = 2;

    // Phase that follows a completed pulse or gap measurement.
    function automatic state_t phase_after(input state_t s);
        state_t n;
        case (s)
            ST_P1:   n = ST_G1;
            ST_G1:   n = ST_P2;
            ST_P2:   n = ST_G2;
            ST_G2:   n = ST_P3;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pulse_seq_monitor_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous rf line into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_r;
    logic s2_r;

    // Metastability filter chain, cleared to 0 on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
        end
    end

    assign q = s2_r;

endmodule

// File: rtl/pulse_seq_monitor.sv
// Measures the pi/2-T-pi-T-pi/2 rf pulse train and reports one result per
// sequence. Define PULSE_MON_CHECK_EN to build the width/gap shape checks.
module pulse_seq_monitor
    import pulse_mon_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int TOL       = DEF_TOL,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int MIN_WIDTH = DEF_MIN_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    output logic             seq_valid,
    output logic             seq_ok,
    output logic [2:0]       err,
    output logic [CNT_W-1:0] width1,
    output logic [CNT_W-1:0] width2,
    output logic [CNT_W-1:0] width3,
    output logic [CNT_W-1:0] gap1,
    output logic [CNT_W-1:0] gap2,
    output logic [15:0]      seq_count
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_W_C   = CNT_W'(MIN_WIDTH);

    logic s2_s, s3_r, rise_s, fall_s;
    state_t state_r, state_next;
    logic [CNT_W-1:0] cnt_r, cnt_next, cnt_inc_s;
    logic start_s, latch_s, finish_s, abort_s;
    logic shape_err_s, gap_err_s;

    logic             seq_valid_r, seq_valid_next;
    logic             seq_ok_r, seq_ok_next;
    logic [2:0]       err_r, err_next;
    logic [CNT_W-1:0] width1_r, width2_r, width3_r, gap1_r, gap2_r;
    logic [CNT_W-1:0] width1_next, width2_next, width3_next, gap1_next, gap2_next;
    logic [15:0]      seq_count_r, seq_count_next;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pulse_in),
        .q     (s2_s)
    );

    assign rise_s    = s2_s & ~s3_r;
    assign fall_s    = ~s2_s & s3_r;
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;

`ifdef PULSE_MON_CHECK_EN
    localparam int DW = CNT_W + 2;
    logic signed [DW-1:0] d_w2_s, d_w3_s, d_gap_s;

    function automatic logic exceeds_tol(input logic signed [DW-1:0] d);
        return (d > $signed(DW'(TOL))) || (d < -$signed(DW'(TOL)));
    endfunction

    // width3 is still in cnt_r on the finishing edge.
    assign d_w2_s      = $signed({2'b00, width2_r}) - $signed({1'b0, width1_r, 1'b0});
    assign d_w3_s      = $signed({2'b00, cnt_r}) - $signed({2'b00, width1_r});
    assign d_gap_s     = $signed({2'b00, gap2_r}) - $signed({2'b00, gap1_r});
    assign shape_err_s = exceeds_tol(d_w2_s) | exceeds_tol(d_w3_s);
    assign gap_err_s   = exceeds_tol(d_gap_s);
`else
    assign shape_err_s = 1'b0;
    assign gap_err_s   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state and run-counter control.
    always_comb begin
        state_next = state_r;
        cnt_next   = cnt_r;
        start_s    = 1'b0;
        latch_s    = 1'b0;
        finish_s   = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_next = ST_P1;
                    cnt_next   = CNT_ONE;
                    start_s    = 1'b1;
                end else begin
                    cnt_next   = CNT_ZERO;
                end
            end
            ST_P1, ST_P2, ST_P3: begin
                if (fall_s && (cnt_r < MIN_W_C)) begin
                    abort_s    = 1'b1;
                    state_next = ST_IDLE;
                    cnt_next   = CNT_ZERO;
                end else if (fall_s) begin
                    latch_s    = 1'b1;
                    finish_s   = (state_r == ST_P3);
                    state_next = phase_after(state_r);
                    cnt_next   = (state_r == ST_P3) ? CNT_ZERO : CNT_ONE;
                end else if (cnt_inc_s >= TIMEOUT_C) begin
                    abort_s    = 1'b1;
                    state_next = ST_IDLE;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next   = cnt_inc_s;
                end
            end
            ST_G1, ST_G2: begin
                if (rise_s) begin
                    latch_s    = 1'b1;
                    state_next = phase_after(state_r);
                    cnt_next   = CNT_ONE;
                end else if (cnt_inc_s >= TIMEOUT_C) begin
                    abort_s    = 1'b1;
                    state_next = ST_IDLE;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next   = cnt_inc_s;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // Next values of the result fields, strobe and sequence counter.
    always_comb begin
        seq_valid_next = 1'b0;
        seq_ok_next    = seq_ok_r;
        err_next       = err_r;
        width1_next    = width1_r;
        width2_next    = width2_r;
        width3_next    = width3_r;
        gap1_next      = gap1_r;
        gap2_next      = gap2_r;
        seq_count_next = seq_count_r;
        if (start_s) begin
            width1_next = CNT_ZERO;
            width2_next = CNT_ZERO;
            width3_next = CNT_ZERO;
            gap1_next   = CNT_ZERO;
            gap2_next   = CNT_ZERO;
        end else if (latch_s) begin
            case (state_r)
                ST_P1:   width1_next = cnt_r;
                ST_G1:   gap1_next   = cnt_r;
                ST_P2:   width2_next = cnt_r;
                ST_G2:   gap2_next   = cnt_r;
                ST_P3:   width3_next = cnt_r;
                default: width1_next = width1_r;
            endcase
        end else begin
            width1_next = width1_r;
        end
        if (finish_s) begin
            seq_valid_next      = 1'b1;
            err_next            = 3'b000;
            err_next[ERR_SHAPE] = shape_err_s;
            err_next[ERR_GAP]   = gap_err_s;
            seq_ok_next         = ~(shape_err_s | gap_err_s);
            seq_count_next      = (shape_err_s | gap_err_s) ? seq_count_r : seq_count_r + 16'd1;
        end else if (abort_s) begin
            seq_valid_next      = 1'b1;
            err_next            = 3'b000;
            err_next[ERR_ABORT] = 1'b1;
            seq_ok_next         = 1'b0;
        end else begin
            seq_valid_next = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_r        <= 1'b0;
            cnt_r       <= CNT_ZERO;
            seq_valid_r <= 1'b0;
            seq_ok_r    <= 1'b0;
            err_r       <= 3'b000;
            width1_r    <= CNT_ZERO;
            width2_r    <= CNT_ZERO;
            width3_r    <= CNT_ZERO;
            gap1_r      <= CNT_ZERO;
            gap2_r      <= CNT_ZERO;
            seq_count_r <= 16'd0;
        end else begin
            s3_r        <= s2_s;
            cnt_r       <= cnt_next;
            seq_valid_r <= seq_valid_next;
            seq_ok_r    <= seq_ok_next;
            err_r       <= err_next;
            width1_r    <= width1_next;
            width2_r    <= width2_next;
            width3_r    <= width3_next;
            gap1_r      <= gap1_next;
            gap2_r      <= gap2_next;
            seq_count_r <= seq_count_next;
        end
    end

    assign seq_valid = seq_valid_r;
    assign seq_ok    = seq_ok_r;
    assign err       = err_r;
    assign width1    = width1_r;
    assign width2    = width2_r;
    assign width3    = width3_r;
    assign gap1      = gap1_r;
    assign gap2      = gap2_r;
    assign seq_count = seq_count_r;

endmodule

// File: tb/tb_pulse_seq_monitor.sv
// Bench for pulse_seq_monitor: segment-level reference model of the pulse
// train rules, directed and randomized pulse streams, strobe scoreboard.
module tb_pulse_seq_monitor;

    localparam int CNT_W = 32;
    localparam int TOL   = 4;
    localparam int TO    = 1000;
    localparam int MINW  = 2;
`ifdef PULSE_MON_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pulse_in;
    logic             seq_valid, seq_ok;
    logic [2:0]       err;
    logic [CNT_W-1:0] width1, width2, width3, gap1, gap2;
    logic [15:0]      seq_count;

    pulse_seq_monitor #(
        .CNT_W(CNT_W), .TOL(TOL), .TIMEOUT(TO), .MIN_WIDTH(MINW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pulse_in(pulse_in),
        .seq_valid(seq_valid), .seq_ok(seq_ok), .err(err),
        .width1(width1), .width2(width2), .width3(width3),
        .gap1(gap1), .gap2(gap2), .seq_count(seq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        ok;
        logic [2:0]  e;
        logic [31:0] w1, w2, w3, g1, g2;
        logic [15:0] cnt;
    } res_t;

    res_t act_q[$];
    res_t exp_q[$];
    res_t m_last;
    logic [15:0] m_count;
    int   m_f[5];
    int   seg[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        res_t r;
        if (seq_valid === 1'b1) begin
            r.cyc = cyc; r.ok = seq_ok; r.e = err;
            r.w1 = width1; r.w2 = width2; r.w3 = width3;
            r.g1 = gap1; r.g2 = gap2; r.cnt = seq_count;
            act_q.push_back(r);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act_v, exp_v, $time);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic res_t zero_res();
        res_t r;
        r.cyc = 0; r.ok = 1'b0; r.e = 3'b000;
        r.w1 = 0; r.w2 = 0; r.w3 = 0; r.g1 = 0; r.g2 = 0; r.cnt = 16'd0;
        return r;
    endfunction

    task automatic emit(input int c, input logic ok, input logic [2:0] e);
        res_t r;
        r.cyc = c; r.ok = ok; r.e = e;
        r.w1 = m_f[0]; r.g1 = m_f[1]; r.w2 = m_f[2]; r.g2 = m_f[3]; r.w3 = m_f[4];
        if (ok) m_count = m_count + 16'd1;
        r.cnt = m_count;
        exp_q.push_back(r);
        m_last = r;
    endtask

    // Walk the stream one segment at a time: even entries high, odd low.
    // A strobe lands 3 edges after the first low sample (finish/glitch)
    // or on the TO-th sample of an over-long segment (timeout).
    task automatic model_stream(input int k0);
        int p, ph, len;
        logic se, ge;
        p = 0; ph = 0;
        for (int i = 0; i < seg.size(); i++) begin
            len = seg[i];
            if ((i % 2 == 0) && (ph == 0)) begin
                ph = 1;
                for (int j = 0; j < 5; j++) m_f[j] = 0;
            end
            if (ph != 0) begin
                if (len >= TO) begin
                    emit(k0 + p + TO + 2, 1'b0, 3'b100);
                    ph = 0;
                end else if ((i % 2 == 0) && (len < MINW)) begin
                    emit(k0 + p + len + 3, 1'b0, 3'b100);
                    ph = 0;
                end else begin
                    m_f[ph-1] = len;
                    if (ph == 5) begin
                        se = CHK_EN && ((iabs(m_f[2] - 2*m_f[0]) > TOL) || (iabs(m_f[4] - m_f[0]) > TOL));
                        ge = CHK_EN && (iabs(m_f[3] - m_f[1]) > TOL);
                        emit(k0 + p + len + 3, !(se || ge), {1'b0, ge, se});
                        ph = 0;
                    end else begin
                        ph++;
                    end
                end
            end
            p += len;
        end
    endtask

    task automatic drive_level(input logic v, input int n);
        pulse_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_held();
        check_eq("idle_valid", seq_valid, 1'b0);
        check_eq("held_ok", seq_ok, m_last.ok);
        check_eq("held_err", err, m_last.e);
        check_eq("held_w1", width1, m_last.w1);
        check_eq("held_g2", gap2, m_last.g2);
        check_eq("held_count", seq_count, m_count);
    endtask

    // Drive seg (plus a flushing low tail), then score strobes against the model.
    task automatic run_stream();
        int k0, n;
        res_t a, x;
        seg.push_back(TO + 5);
        k0 = cyc;
        model_stream(k0);
        for (int i = 0; i < seg.size(); i++) drive_level((i % 2) == 0, seg[i]);
        check_eq("n_strobes", act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            a = act_q[i]; x = exp_q[i];
            check_eq("strobe_cyc", a.cyc, x.cyc);
            check_eq("seq_ok", a.ok, x.ok);
            check_eq("err", a.e, x.e);
            check_eq("width1", a.w1, x.w1);
            check_eq("width2", a.w2, x.w2);
            check_eq("width3", a.w3, x.w3);
            check_eq("gap1", a.g1, x.g1);
            check_eq("gap2", a.g2, x.g2);
            check_eq("seq_count", a.cnt, x.cnt);
        end
        check_held();
        act_q.delete();
        exp_q.delete();
        seg.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, seq_valid, 1'b0);
        check_eq({tag, "_ok"}, seq_ok, 1'b0);
        check_eq({tag, "_err"}, err, 3'b000);
        check_eq({tag, "_fields"}, {width1 | width2 | width3 | gap1 | gap2}, 32'd0);
        check_eq({tag, "_count"}, seq_count, 16'd0);
    endtask

    function automatic int jitter(input int base, input int span);
        int v;
        v = base + int'($urandom_range(0, 2 * span)) - span;
        return (v < 1) ? 1 : v;
    endfunction

    task automatic gen_random();
        int w1, g1, w2, g2, w3, r;
        for (int s = 0; s < 4; s++) begin
            r  = int'($urandom_range(0, 9));
            w1 = int'($urandom_range(2, 40));
            g1 = int'($urandom_range(1, 80));
            w2 = jitter(2 * w1, 6);
            g2 = jitter(g1, 6);
            w3 = jitter(w1, 6);
            if (r == 0) w2 = 1;
            if (r == 1) g1 = int'($urandom_range(TO - 2, TO + 20));
            if (r == 2) w1 = int'($urandom_range(TO - 2, TO + 5));
            if (s != 0) seg.push_back(int'($urandom_range(1, 6)));
            seg.push_back(w1); seg.push_back(g1); seg.push_back(w2);
            seg.push_back(g2); seg.push_back(w3);
        end
    endtask

    initial begin
        m_count  = 16'd0;
        m_last   = zero_res();
        rst_n    = 1'b0;
        pulse_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        drive_level(1'b0, 4);

        seg = '{333, 300, 666, 300, 333};         run_stream();  // nominal
        seg = '{333, 300, 676, 300, 333};         run_stream();  // width2 off by 10
        seg = '{33, 300, 66, 310, 33};            run_stream();  // gap2 off by 10
        seg = '{333};                             run_stream();  // gap1 timeout
        seg = '{1, 10, 33, 50, 66, 50, 33};       run_stream();  // glitch then nominal
        seg = '{33, 20, 66, 20, 33, 1, 33, 20, 66, 20, 33}; run_stream();  // back-to-back
        seg = '{10, TO - 1, 20, 5, 10};           run_stream();  // longest legal gap
        seg = '{TO, 7, 20, 30, 44, 30, 24};       run_stream();  // width timeout, then TOL edge
        seg = '{20, 30, 45, 30, 20};              run_stream();  // TOL+1 on width2

        // Asynchronous reset while the monitor is in the second gap.
        drive_level(1'b1, 20); drive_level(1'b0, 10);
        drive_level(1'b1, 40); drive_level(1'b0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_level(1'b0, 2);
        check_eq("rst_no_strobe", act_q.size(), 0);
        act_q.delete();
        m_count = 16'd0;
        m_last  = zero_res();
        seg = '{333, 300, 666, 300, 333};         run_stream();

        for (int k = 0; k < 12; k++) begin
            gen_random();
            run_stream();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
